// File: rtl/colour_channel_select_if.sv
// Bundle between the pattern generators (master) and the channel selector (slave).
// The master drives enable, select and the packed channel words; the slave drives the selected word and status flags.
interface colour_channel_select_if #(
    parameter int WIDTH = 24,
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
);
    logic                    sysOn;
    logic [SEL_W-1:0]        sel;
    logic [N_CH*WIDTH-1:0]   data_in;
    logic [WIDTH-1:0]        out;
    logic                    busy;
    logic                    sel_err;

    modport master (
        output sysOn, sel, data_in,
        input  out, busy, sel_err
    );

    modport slave (
        input  sysOn, sel, data_in,
        output out, busy, sel_err
    );
endinterface

// File: rtl/colour_channel_select.sv
// Registered N-channel word selector with break-before-make switching.
// A channel change blanks the output for GAP cycles before the new channel is driven.
module colour_channel_select #(
    parameter int WIDTH = 24,
    parameter int N_CH  = 4,
    parameter int SEL_W = 2,
    parameter int GAP   = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    colour_channel_select_if.slave bus
);
    localparam int CNT_W = $clog2(GAP) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GAP - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_STEADY,
        ST_BLANK
    } state_e;

    state_e             state_q;
    logic [SEL_W-1:0]   active_q;
    logic [SEL_W-1:0]   target_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   out_q;
    logic               busy_q;
    logic               sel_err_q;

    logic               sel_valid;
    logic [WIDTH-1:0]   sel_word;
    logic [WIDTH-1:0]   active_word;
    logic [WIDTH-1:0]   target_word;

    // Loop-based lookup so an out-of-range index (N_CH < 2**SEL_W) yields zero instead of indexing past the bus.
    function automatic logic [WIDTH-1:0] pick_word(input logic [SEL_W-1:0]      idx,
                                                   input logic [N_CH*WIDTH-1:0] words);
        logic [WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (idx == SEL_W'(i)) w = words[i*WIDTH +: WIDTH];
        end
        return w;
    endfunction

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        sel_valid   = (int'(bus.sel) < N_CH);
        sel_word    = pick_word(bus.sel,  bus.data_in);
        active_word = pick_word(active_q, bus.data_in);
        target_word = pick_word(target_q, bus.data_in);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_OFF;
            active_q  <= '0;
            target_q  <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            busy_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= !sel_valid;

            if (!bus.sysOn) begin
                // Switching off abandons any pending change; the next power-up starts clean.
                state_q  <= ST_OFF;
                out_q    <= '0;
                busy_q   <= 1'b0;
                cnt_q    <= '0;
                target_q <= '0;
            end else begin
                case (state_q)
                    ST_OFF: begin
                        if (sel_valid) begin
                            active_q <= bus.sel;
                            out_q    <= sel_word;
                            state_q  <= ST_STEADY;
                        end else begin
                            out_q <= '0;
                        end
                    end

                    ST_STEADY: begin
                        if (sel_valid && (bus.sel != active_q)) begin
                            target_q <= bus.sel;
                            cnt_q    <= CNT_LOAD;
                            out_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= ST_BLANK;
                        end else begin
                            out_q <= active_word;
                        end
                    end

                    ST_BLANK: begin
                        // A new valid request restarts the full gap, even a return to the old channel.
                        if (sel_valid && (bus.sel != target_q)) begin
                            target_q <= bus.sel;
                            cnt_q    <= CNT_LOAD;
                            out_q    <= '0;
                        end else if (cnt_q == '0) begin
                            active_q <= target_q;
                            out_q    <= target_word;
                            busy_q   <= 1'b0;
                            state_q  <= ST_STEADY;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                            out_q <= '0;
                        end
                    end

                    default: begin
                        state_q <= ST_OFF;
                        out_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.out     = out_q;
    assign bus.busy    = busy_q;
    assign bus.sel_err = sel_err_q;
endmodule

// File: tb/tb_colour_channel_select.sv
// Directed bench for colour_channel_select: a 4-channel and a 3-channel instance share clock and reset.
// Expected words come from the bench's own copy of the channel data.
module tb_colour_channel_select;
    localparam int W   = 24;
    localparam int GAP = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    colour_channel_select_if #(.WIDTH(W), .N_CH(4), .SEL_W(2)) bus4 ();
    colour_channel_select_if #(.WIDTH(W), .N_CH(3), .SEL_W(2)) bus3 ();

    colour_channel_select #(.WIDTH(W), .N_CH(4), .SEL_W(2), .GAP(GAP)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    colour_channel_select #(.WIDTH(W), .N_CH(3), .SEL_W(2), .GAP(GAP)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    logic [W-1:0] ch4 [4];
    logic [W-1:0] ch3 [3];
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set4(input int i, input logic [W-1:0] v);
        ch4[i] = v;
        bus4.data_in[i*W +: W] = v;
    endtask

    task automatic set3(input int i, input logic [W-1:0] v);
        ch3[i] = v;
        bus3.data_in[i*W +: W] = v;
    endtask

    task automatic expect4(input string tag, input logic [W-1:0] o, input logic b);
        check({tag, ".out"},  32'(bus4.out),  32'(o));
        check({tag, ".busy"}, 32'(bus4.busy), 32'(b));
    endtask

    task automatic expect3(input string tag, input logic [W-1:0] o, input logic b, input logic e);
        check({tag, ".out"},     32'(bus3.out),     32'(o));
        check({tag, ".busy"},    32'(bus3.busy),    32'(b));
        check({tag, ".sel_err"}, 32'(bus3.sel_err), 32'(e));
    endtask

    initial begin
        bus4.sysOn   = 1'b1;
        bus4.sel     = 2'd2;
        bus4.data_in = '0;
        bus3.sysOn   = 1'b1;
        bus3.sel     = 2'd0;
        bus3.data_in = '0;
        for (int i = 0; i < 4; i++) set4(i, W'($urandom) | 24'h000001);
        set3(0, 24'h123456);
        set3(1, 24'h654321);
        set3(2, 24'hABCDEF);

        // Held in reset with live inputs: outputs stay cleared.
        repeat (3) tick;
        expect4("rst", '0, 1'b0);
        check("rst.sel_err", 32'(bus4.sel_err), 32'd0);

        // Power-up selects ch2 on the first edge, no gap.
        rst_n = 1'b1;
        tick;
        expect4("pwrup", ch4[2], 1'b0);

        bus4.sel = 2'd0;
        tick;
        expect4("to0.start", '0, 1'b1);
        repeat (GAP - 1) tick;
        expect4("to0.last_zero", '0, 1'b1);
        tick;
        expect4("to0.end", ch4[0], 1'b0);

        // Live data tracking with one cycle of latency.
        set4(0, 24'hFF0000);
        tick;
        expect4("t2.a", 24'hFF0000, 1'b0);
        set4(0, 24'h00FF00);
        check("t2.latency", 32'(bus4.out), 32'h00FF0000);
        tick;
        expect4("t2.b", 24'h00FF00, 1'b0);

        // Plain switch 0 -> 1: exactly GAP zero words, then ch1.
        set4(1, 24'h0000FF);
        bus4.sel = 2'd1;
        for (int i = 0; i < GAP; i++) begin
            tick;
            expect4($sformatf("t3.gap%0d", i), '0, 1'b1);
        end
        tick;
        expect4("t3.new", 24'h0000FF, 1'b0);

        // Retarget mid-gap: 3 zeros, then a full fresh gap, then ch3.
        bus4.sel = 2'd0;
        repeat (GAP + 1) tick;
        expect4("t4.on0", ch4[0], 1'b0);
        set4(3, 24'hA5C35A);
        bus4.sel = 2'd1;
        for (int i = 0; i < 3; i++) begin
            tick;
            expect4($sformatf("t4.first%0d", i), '0, 1'b1);
        end
        bus4.sel = 2'd3;
        for (int i = 0; i < GAP; i++) begin
            tick;
            expect4($sformatf("t4.second%0d", i), '0, 1'b1);
        end
        tick;
        expect4("t4.new", 24'hA5C35A, 1'b0);

        // sysOn drop mid-gap, then power-up straight onto ch1.
        bus4.sel = 2'd0;
        repeat (2) tick;
        expect4("t5.gap", '0, 1'b1);
        bus4.sysOn = 1'b0;
        tick;
        expect4("t5.off", '0, 1'b0);
        bus4.sel = 2'd2;
        tick;
        expect4("t5.still_off", '0, 1'b0);
        bus4.sysOn = 1'b1;
        bus4.sel   = 2'd1;
        tick;
        expect4("t5.pwrup", ch4[1], 1'b0);

        // Three-channel instance: sel=3 is invalid and ignored.
        expect3("t6.base", ch3[0], 1'b0, 1'b0);
        bus3.sel = 2'd3;
        tick;
        expect3("t6.bad", ch3[0], 1'b0, 1'b1);
        tick;
        expect3("t6.bad2", ch3[0], 1'b0, 1'b1);
        bus3.sel = 2'd2;
        tick;
        expect3("t6.gap0", '0, 1'b1, 1'b0);
        repeat (GAP - 1) tick;
        expect3("t6.gap_last", '0, 1'b1, 1'b0);
        tick;
        expect3("t6.new", ch3[2], 1'b0, 1'b0);

        // Async reset mid-blank clears outputs without waiting for an edge.
        bus4.sel = 2'd3;
        tick;
        expect4("rst_mid.blank", '0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        expect4("rst_mid.cleared", '0, 1'b0);
        tick;
        rst_n = 1'b1;
        tick;
        expect4("rst_mid.pwrup", ch4[3], 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
